// File: rtl/keypad_scanner_if.sv
// Key-event handshake between the keypad scanner (master) and its consumer (slave).
// CW must match the scanner's key-code width, $clog2(ROWS*COLS).
interface keypad_scanner_if #(
   parameter int CW = 4
);
   logic          key_valid;
   logic          key_ready;
   logic [CW-1:0] key_code;
   logic          key_release;

   modport master (output key_valid, output key_code, output key_release, input key_ready);
   modport slave  (input key_valid, input key_code, input key_release, output key_ready);
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobing, per-key debounce and a key-event FIFO.
// Define KEYPAD_RELEASE_EVT_EN to also queue release events (key_release = 1).
module keypad_scanner #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int DEBOUNCE   = 3,
   parameter int FIFO_DEPTH = 4,
   localparam int CW        = $clog2(ROWS*COLS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ROWS-1:0]        rows_in,
   output logic [COLS-1:0]        cols_out,
   keypad_scanner_if.master       evt,
   output logic [ROWS*COLS-1:0]   key_down,
   output logic                   overflow
);
   localparam int NK  = ROWS*COLS;
   localparam int DVW = $clog2(SCAN_DIV);
   localparam int CLW = $clog2(COLS);
   localparam int RW  = $clog2(ROWS);
   localparam int AW  = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_RELEASE_EVT_EN
   localparam bit REL_EN = 1'b1;
   localparam int DW     = CW + 1;
`else
   localparam bit REL_EN = 1'b0;
   localparam int DW     = CW;
`endif

   logic [ROWS-1:0] rows_meta_reg, rows_sync_reg;
   logic            run_reg;
   logic [DVW-1:0]  div_reg;
   logic [CLW-1:0]  col_reg;
   logic [COLS-1:0] cols_reg;
   logic            sample;

   always_ff @(posedge clk) begin
      if (rst) begin
         rows_meta_reg <= '0;
         rows_sync_reg <= '0;
      end else begin
         rows_meta_reg <= rows_in;
         rows_sync_reg <= rows_meta_reg;
      end
   end

   assign sample = run_reg && (div_reg == DVW'(SCAN_DIV-1));

   // run_reg delays the first strobe by one cycle so the divider starts at 0 with col 0 driven.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_reg  <= 1'b0;
         div_reg  <= '0;
         col_reg  <= '0;
         cols_reg <= '0;
      end else if (!run_reg) begin
         run_reg  <= 1'b1;
         cols_reg <= COLS'(1);
      end else if (sample) begin
         div_reg  <= '0;
         col_reg  <= (col_reg == CLW'(COLS-1)) ? '0 : col_reg + 1'b1;
         cols_reg <= {cols_reg[COLS-2:0], cols_reg[COLS-1]};
      end else begin
         div_reg  <= div_reg + 1'b1;
      end
   end

   assign cols_out = cols_reg;

   logic [NK-1:0] evt_key;

   genvar gi;
   generate
      for (gi = 0; gi < NK; gi++) begin : g_key
         localparam int KC = gi / ROWS;
         localparam int KR = gi % ROWS;
         logic [3:0] cnt_reg;
         logic       down_reg;
         logic       hit, smp, flip;

         assign hit  = sample && (col_reg == CLW'(KC));
         assign smp  = rows_sync_reg[KR];
         assign flip = hit && (smp != down_reg) && (cnt_reg == 4'(DEBOUNCE-1));
         assign evt_key[gi]  = flip && (REL_EN || !down_reg);
         assign key_down[gi] = down_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg  <= '0;
               down_reg <= 1'b0;
            end else if (hit) begin
               if (smp == down_reg) begin
                  cnt_reg <= '0;
               end else if (flip) begin
                  cnt_reg  <= '0;
                  down_reg <= ~down_reg;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end
      end
   endgenerate

   logic [ROWS-1:0] pend_reg, pend_set, pick;
   logic [CLW-1:0]  pend_col_reg;
   logic [RW-1:0]   pick_row;
   logic            push;
   logic [CW-1:0]   push_code;
   logic [DW-1:0]   push_data;

   always_comb begin
      pend_set = '0;
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            pend_set[r] = pend_set[r] | evt_key[c*ROWS+r];
   end

   always_comb begin
      pick     = '0;
      pick_row = '0;
      for (int r = ROWS-1; r >= 0; r--) begin
         if (pend_reg[r]) begin
            pick     = ROWS'(1) << r;
            pick_row = RW'(r);
         end
      end
   end

   assign push      = |pend_reg;
   assign push_code = CW'(pend_col_reg) * CW'(ROWS) + CW'(pick_row);

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_reg     <= '0;
         pend_col_reg <= '0;
      end else begin
         pend_reg <= (pend_reg & ~pick) | pend_set;
         if (sample)
            pend_col_reg <= col_reg;
      end
   end

`ifdef KEYPAD_RELEASE_EVT_EN
   logic [ROWS-1:0] pend_rel_reg, rel_set;

   // A flipping key that is currently down is being released.
   always_comb begin
      rel_set = '0;
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            rel_set[r] = rel_set[r] | (evt_key[c*ROWS+r] & key_down[c*ROWS+r]);
   end

   always_ff @(posedge clk) begin
      if (rst)
         pend_rel_reg <= '0;
      else if (sample)
         pend_rel_reg <= rel_set;
   end

   assign push_data = {pend_rel_reg[pick_row], push_code};
`else
   assign push_data = push_code;
`endif

   logic [DW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_reg, rd_reg, count;
   logic          full, valid, pop, accept, overflow_reg;
   logic [DW-1:0] head;

   assign count  = wr_reg - rd_reg;
   assign full   = (count == (AW+1)'(FIFO_DEPTH));
   assign valid  = (count != '0);
   assign pop    = valid && evt.key_ready;
   assign accept = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_reg[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_reg       <= '0;
         rd_reg       <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (accept)
            wr_reg <= wr_reg + 1'b1;
         if (pop)
            rd_reg <= rd_reg + 1'b1;
         overflow_reg <= push && full && !pop;
      end
   end

   assign head          = mem[rd_reg[AW-1:0]];
   assign evt.key_valid = valid;
   assign evt.key_code  = valid ? head[CW-1:0] : '0;
`ifdef KEYPAD_RELEASE_EVT_EN
   assign evt.key_release = valid && head[CW];
`else
   assign evt.key_release = 1'b0;
`endif
   assign overflow = overflow_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: event-level keypad model, per-cycle compare, directed and random scenarios.
module tb_keypad_scanner;
   localparam int ROWS = 4, COLS = 4, SD = 8, DEB = 3, DEPTH = 4;
   localparam int NK = ROWS*COLS, CW = 4, SCAN = SD*COLS;
`ifdef KEYPAD_RELEASE_EVT_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [ROWS-1:0] rows_in;
   logic [COLS-1:0] cols_out;
   logic [NK-1:0]   key_down;
   logic            overflow;
   logic [NK-1:0]   phys = '0;

   keypad_scanner_if #(.CW(CW)) kif ();

   keypad_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .rows_in(rows_in), .cols_out(cols_out),
      .evt(kif), .key_down(key_down), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key connects its column strobe to its row line.
   always_comb begin
      rows_in = '0;
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            if (phys[c*ROWS+r] && cols_out[c]) rows_in[r] = 1'b1;
   end

   typedef struct { int cyc; int code; bit rel; } ev_t;
   ev_t           infl[$];
   ev_t           m_q[$];
   bit            m_run = 1'b0;
   int            m_t = 0;
   logic [NK-1:0] m_down = '0;
   int            m_cnt [NK];
   bit            m_ovf = 1'b0;
   logic [NK-1:0] ph0 = '0, ph1 = '0, ph2 = '0;
   int            cyc = 0;
   int            n_cmp = 0, n_fail = 0;
   bit            chk_en = 1'b0;
   int            log_q[$];
   int            logc_q[$];
   int            ovf_seen = 0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [COLS-1:0] exp_cols();
      logic [COLS-1:0] one;
      one = 1;
      return m_run ? (one << ((m_t / SD) % COLS)) : '0;
   endfunction

   // Advances the model across the clock edge that ends cycle 'cyc'.
   task automatic model_edge();
      ev_t e;
      int  col, j, k;
      bit  v;
      ph2 = ph1; ph1 = ph0; ph0 = phys;
      if (rst) begin
         infl.delete(); m_q.delete();
         m_run = 0; m_t = 0; m_down = '0; m_ovf = 0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
         return;
      end
      m_ovf = 0;
      if (m_q.size() > 0 && kif.key_ready) void'(m_q.pop_front());
      if (infl.size() > 0 && infl[0].cyc == cyc) begin
         e = infl.pop_front();
         if (m_q.size() < DEPTH) m_q.push_back(e);
         else m_ovf = 1;
      end
      if (!m_run) begin
         m_run = 1; m_t = 0;
      end else begin
         if (m_t % SD == SD-1) begin
            col = (m_t / SD) % COLS;
            j = 0;
            for (int r = 0; r < ROWS; r++) begin
               k = col*ROWS + r;
               v = ph2[k];
               if (v == m_down[k]) m_cnt[k] = 0;
               else begin
                  m_cnt[k]++;
                  if (m_cnt[k] == DEB) begin
                     m_cnt[k] = 0;
                     m_down[k] = v;
                     if (v || REL) begin
                        infl.push_back('{cyc+1+j, k, !v});
                        j++;
                     end
                  end
               end
            end
         end
         m_t++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      model_edge();
      cyc++;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) step();
   endtask

   // Changes the pressed-key set at the start of a column-0 dwell.
   task automatic set_keys(input logic [NK-1:0] v);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(m_run && (m_t % SCAN) == 0) && n < SCAN + 4);
      if (!(m_run && (m_t % SCAN) == 0)) begin
         n_cmp++; n_fail++;
         $display("FAIL align: no column-0 dwell start within %0d cycles", n);
      end
      phys = v;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      step();
      rst = 1'b0;
      log_q.delete(); logc_q.delete(); ovf_seen = 0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("cols_out", cols_out, exp_cols());
         cmp("key_valid", kif.key_valid, m_q.size() > 0);
         cmp("key_down", key_down, m_down);
         cmp("overflow", overflow, m_ovf);
         if (m_q.size() > 0) begin
            cmp("key_code", kif.key_code, m_q[0].code);
            cmp("key_release", kif.key_release, m_q[0].rel);
         end
         if (kif.key_valid && kif.key_ready) begin
            log_q.push_back(int'(kif.key_code) | (int'(kif.key_release) << 8));
            logc_q.push_back(cyc);
         end
         if (overflow) ovf_seen++;
      end
   end

   function automatic int log_at(input int i);
      return (i < log_q.size()) ? log_q[i] : -1;
   endfunction

   function automatic int gap(input int a, input int b);
      return (b < logc_q.size()) ? logc_q[b] - logc_q[a] : -1;
   endfunction

   initial begin
      kif.key_ready = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      chk_en = 1'b1;
      cmp("rst_cols", cols_out, 0);
      cmp("rst_valid", kif.key_valid, 0);
      cmp("rst_down", key_down, 0);
      cmp("rst_ovf", overflow, 0);
      rst = 1'b0;
      step();
      cmp("first_cols", cols_out, 1);

      // Single held key 5 (row1/col1)
      reset_dut();
      kif.key_ready = 1'b1;
      set_keys(16'h0020);
      wait_cycles(4*SCAN);
      cmp("t1_down", key_down, 16'h0020);
      cmp("t1_nevt", log_q.size(), 1);
      cmp("t1_code", log_at(0), 5);
      set_keys(16'h0000);
      wait_cycles(4*SCAN);
      cmp("t1_down_rel", key_down, 0);
`ifdef KEYPAD_RELEASE_EVT_EN
      cmp("t1_nevt_rel", log_q.size(), 2);
      cmp("t1_rel_code", log_at(1), 5 | 256);
`else
      cmp("t1_nevt_rel", log_q.size(), 1);
`endif

      // Bounce on key 5: alternate every scan
      reset_dut();
      for (int i = 0; i < 10; i++) set_keys((i % 2 == 0) ? 16'h0020 : 16'h0000);
      set_keys(16'h0000);
      wait_cycles(2*SCAN);
      cmp("t2_nevt", log_q.size(), 0);
      cmp("t2_down", key_down, 0);

      // Two keys on col3: codes 12 and 14 on consecutive cycles
      reset_dut();
      set_keys(16'h5000);
      wait_cycles(4*SCAN);
      cmp("t3_down", key_down, 16'h5000);
      cmp("t3_nevt", log_q.size(), 2);
      cmp("t3_code0", log_at(0), 12);
      cmp("t3_code1", log_at(1), 14);
      cmp("t3_gap", gap(0, 1), 1);
      set_keys(16'h0000);
      wait_cycles(4*SCAN);

      // Backpressure: five presses into a four-deep queue
      reset_dut();
      kif.key_ready = 1'b0;
      set_keys(16'h001F);
      wait_cycles(4*SCAN);
      cmp("t4_ovf", ovf_seen, 1);
      cmp("t4_valid", kif.key_valid, 1);
      kif.key_ready = 1'b1;
      wait_cycles(8);
      cmp("t4_nevt", log_q.size(), 4);
      for (int i = 0; i < 4; i++) cmp("t4_code", log_at(i), i);
      cmp("t4_gap", gap(0, 3), 3);
      set_keys(16'h0000);
      wait_cycles(4*SCAN);

      // Press then release key 15
      reset_dut();
      set_keys(16'h8000);
      wait_cycles(4*SCAN);
      set_keys(16'h0000);
      wait_cycles(4*SCAN);
      cmp("t5_code", log_at(0), 15);
`ifdef KEYPAD_RELEASE_EVT_EN
      cmp("t5_nevt", log_q.size(), 2);
      cmp("t5_rel", log_at(1), 15 | 256);
`else
      cmp("t5_nevt", log_q.size(), 1);
`endif
      cmp("t5_down", key_down, 0);

      // Reset with two events queued
      reset_dut();
      kif.key_ready = 1'b0;
      set_keys(16'h0003);
      wait_cycles(4*SCAN);
      cmp("t6_valid_pre", kif.key_valid, 1);
      cmp("t6_head", kif.key_code, 0);
      rst = 1'b1;
      step();
      cmp("t6_valid_rst", kif.key_valid, 0);
      cmp("t6_cols_rst", cols_out, 0);
      rst = 1'b0;
      step();
      cmp("t6_cols_run", cols_out, 1);
      log_q.delete(); logc_q.delete();
      kif.key_ready = 1'b1;
      wait_cycles(4*SCAN);
      cmp("t6_nevt", log_q.size(), 2);
      set_keys(16'h0000);
      wait_cycles(4*SCAN);

      // Random key activity and ready throttling
      reset_dut();
      for (int i = 0; i < 3000; i++) begin
         step();
         kif.key_ready = ((i % 400) < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
         if (m_run && (m_t % SD) == 0 && $urandom_range(0, 1) == 1)
            phys[$urandom_range(0, NK-1)] ^= 1'b1;
      end
      kif.key_ready = 1'b1;
      set_keys(16'h0000);
      wait_cycles(5*SCAN);
      cmp("t7_down", key_down, 0);
      cmp("t7_valid", kif.key_valid, 0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end
endmodule
